// File: rtl/regf_arb_pkg.sv
// Shared types and constants for the register-file arbiter.
package regf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;

    localparam logic REQ_I2C   = 1'b0;
    localparam logic REQ_LOCAL = 1'b1;

endpackage

// File: rtl/regf_arbiter_rr_arb2.sv
// Two-input round-robin picker; combinational, the pointer lives in the caller.
module rr_arb2
    import regf_arb_pkg::*;
(
    input  logic [1:0] valids,
    input  logic       rr_ptr,
    output logic [1:0] grant,
    output logic       any
);

    // A lone requester always wins; on contention the pointer breaks the tie.
    always_comb begin
        grant = valids;
        if (valids == 2'b11) begin
            grant = (rr_ptr == REQ_LOCAL) ? 2'b10 : 2'b01;
        end
        any = |valids;
    end

endmodule

// File: rtl/regf_arbiter.sv
// Shares the register-file port between the I2C slave and the local host port.
// Optional ack watchdog enabled by defining REGF_ARB_WATCHDOG_EN.
module regf_arbiter
    import regf_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned WDOG_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r0_valid,
    input  logic                  r0_rw,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_ready,
    output logic                  r0_rsp_valid,
    input  logic                  r1_valid,
    input  logic                  r1_rw,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_ready,
    output logic                  r1_rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  regf_req,
    output logic                  regf_rw,
    output logic [ADDR_WIDTH-1:0] regf_addr,
    output logic [DATA_WIDTH-1:0] regf_wdata,
    input  logic                  regf_ack,
    input  logic [DATA_WIDTH-1:0] regf_rdata
);

    if (WDOG_CYCLES < 2 || WDOG_CYCLES > 255) begin : g_wdog_range
        $error("regf_arbiter: WDOG_CYCLES must be within 2..255");
    end

    arb_state_t            state, state_nxt;
    logic                  rr_ptr, rr_ptr_nxt;
    logic                  owner, owner_nxt;
    logic [1:0]            grant;
    logic                  any;
    logic                  req_nxt, rw_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt, rdata_nxt;
    logic                  rsp0_nxt, rsp1_nxt;

`ifdef REGF_ARB_WATCHDOG_EN
    localparam int unsigned WDOG_CNT_W = 8;
    localparam logic [WDOG_CNT_W-1:0] WDOG_LAST = WDOG_CNT_W'(WDOG_CYCLES - 1);
    logic [WDOG_CNT_W-1:0] wdog_cnt, wdog_nxt;
    logic                  err_nxt;
`else
    assign rsp_err = 1'b0;
`endif

    rr_arb2 u_pick (
        .valids ({r1_valid, r0_valid}),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .any    (any)
    );

    // Acceptance must land in the same cycle as the grant decision.
    assign r0_ready = (state == IDLE) && grant[0];
    assign r1_ready = (state == IDLE) && grant[1];

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        req_nxt    = regf_req;
        rw_nxt     = regf_rw;
        addr_nxt   = regf_addr;
        wdata_nxt  = regf_wdata;
        rdata_nxt  = rsp_rdata;
        rsp0_nxt   = 1'b0;
        rsp1_nxt   = 1'b0;
`ifdef REGF_ARB_WATCHDOG_EN
        err_nxt    = rsp_err;
        wdog_nxt   = wdog_cnt;
`endif
        case (state)
            IDLE: begin
                if (any) begin
                    owner_nxt  = grant[1];
                    rr_ptr_nxt = ~grant[1];
                    rw_nxt     = grant[1] ? r1_rw    : r0_rw;
                    addr_nxt   = grant[1] ? r1_addr  : r0_addr;
                    wdata_nxt  = grant[1] ? r1_wdata : r0_wdata;
                    req_nxt    = 1'b1;
                    state_nxt  = BUSY;
`ifdef REGF_ARB_WATCHDOG_EN
                    wdog_nxt   = '0;
`endif
                end
            end
            BUSY: begin
                if (regf_ack) begin
                    req_nxt   = 1'b0;
                    rdata_nxt = (regf_rw == RW_WRITE) ? '0 : regf_rdata;
                    rsp0_nxt  = (owner == REQ_I2C);
                    rsp1_nxt  = (owner == REQ_LOCAL);
                    state_nxt = RESP;
`ifdef REGF_ARB_WATCHDOG_EN
                    err_nxt   = 1'b0;
                end else if (wdog_cnt == WDOG_LAST) begin
                    // Ack never came: complete with an error so the owner is not stuck.
                    req_nxt   = 1'b0;
                    rdata_nxt = '1;
                    err_nxt   = 1'b1;
                    rsp0_nxt  = (owner == REQ_I2C);
                    rsp1_nxt  = (owner == REQ_LOCAL);
                    state_nxt = RESP;
                end else begin
                    wdog_nxt  = wdog_cnt + WDOG_CNT_W'(1);
`endif
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= REQ_I2C;
            owner        <= REQ_I2C;
            regf_req     <= 1'b0;
            regf_rw      <= RW_READ;
            regf_addr    <= '0;
            regf_wdata   <= '0;
            rsp_rdata    <= '0;
            r0_rsp_valid <= 1'b0;
            r1_rsp_valid <= 1'b0;
`ifdef REGF_ARB_WATCHDOG_EN
            rsp_err      <= 1'b0;
            wdog_cnt     <= '0;
`endif
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_ptr_nxt;
            owner        <= owner_nxt;
            regf_req     <= req_nxt;
            regf_rw      <= rw_nxt;
            regf_addr    <= addr_nxt;
            regf_wdata   <= wdata_nxt;
            rsp_rdata    <= rdata_nxt;
            r0_rsp_valid <= rsp0_nxt;
            r1_rsp_valid <= rsp1_nxt;
`ifdef REGF_ARB_WATCHDOG_EN
            rsp_err      <= err_nxt;
            wdog_cnt     <= wdog_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_regf_arbiter.sv
// Self-checking bench for regf_arbiter: directed scenarios plus random traffic
// checked against a transaction-timeline reference model.
module tb_regf_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
`ifdef REGF_ARB_WATCHDOG_EN
    localparam int unsigned WDOG = 4;
`else
    localparam int unsigned WDOG = 16;
`endif

    typedef struct packed {
        logic          v;
        logic          rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } rq_t;

    localparam rq_t NONE = '0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          r0_valid, r0_rw, r0_ready, r0_rsp_valid;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r1_valid, r1_rw, r1_ready, r1_rsp_valid;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          regf_req, regf_rw, regf_ack;
    logic [AW-1:0] regf_addr;
    logic [DW-1:0] regf_wdata, regf_rdata;

    always #5 clk = ~clk;

    regf_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .r0_valid     (r0_valid),
        .r0_rw        (r0_rw),
        .r0_addr      (r0_addr),
        .r0_wdata     (r0_wdata),
        .r0_ready     (r0_ready),
        .r0_rsp_valid (r0_rsp_valid),
        .r1_valid     (r1_valid),
        .r1_rw        (r1_rw),
        .r1_addr      (r1_addr),
        .r1_wdata     (r1_wdata),
        .r1_ready     (r1_ready),
        .r1_rsp_valid (r1_rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .regf_req     (regf_req),
        .regf_rw      (regf_rw),
        .regf_addr    (regf_addr),
        .regf_wdata   (regf_wdata),
        .regf_ack     (regf_ack),
        .regf_rdata   (regf_rdata)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: one transaction in flight, described by its timeline.
    bit            m_busy, m_pref, m_owner, m_err;
    int            m_grant_cyc, m_ack_cyc, m_free_cyc, m_req_cycles;
    rq_t           m_txn;
    logic [DW-1:0] m_rdata;

    int obs_req_cnt;
    int obs_gcyc[$];
    bit obs_gwho[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic rq_t rand_rq();
        rq_t q;
        q = {1'b1, 1'($urandom), AW'($urandom), DW'($urandom)};
        return q;
    endfunction

    task automatic drive(input rq_t q0, input rq_t q1, input bit ack, input logic [DW-1:0] rd);
        {r0_valid, r0_rw, r0_addr, r0_wdata} = q0;
        {r1_valid, r1_rw, r1_addr, r1_wdata} = q1;
        regf_ack   = ack;
        regf_rdata = rd;
    endtask

    // One clock cycle: drive, predict, sample at the falling edge, compare.
    task automatic step(input rq_t q0, input rq_t q1, input bit ack,
                        input logic [DW-1:0] rd, output bit [1:0] gnt);
        bit e_rdy0, e_rdy1, e_req, e_rsp0, e_rsp1, win;
        e_rdy0 = 1'b0; e_rdy1 = 1'b0; e_req = 1'b0; e_rsp0 = 1'b0; e_rsp1 = 1'b0;
        gnt = 2'b00;
        @(posedge clk);
        #1;
        drive(q0, q1, ack, rd);
        if (m_busy && m_ack_cyc >= 0 && cyc == m_ack_cyc + 1) begin
            e_rsp0     = !m_owner;
            e_rsp1     = m_owner;
            m_busy     = 1'b0;
            m_free_cyc = cyc + 1;
        end
        if (m_busy && cyc > m_grant_cyc && m_ack_cyc < 0) begin
            e_req = 1'b1;
            m_req_cycles++;
            if (ack) begin
                m_ack_cyc = cyc;
                m_rdata   = m_txn.rw ? '0 : rd;
                m_err     = 1'b0;
            end
`ifdef REGF_ARB_WATCHDOG_EN
            else if (m_req_cycles == int'(WDOG)) begin
                m_ack_cyc = cyc;
                m_rdata   = '1;
                m_err     = 1'b1;
            end
`endif
        end
        if (!m_busy && cyc >= m_free_cyc && (q0.v || q1.v)) begin
            win          = (q0.v && q1.v) ? m_pref : q1.v;
            m_pref       = !win;
            m_owner      = win;
            m_txn        = win ? q1 : q0;
            m_busy       = 1'b1;
            m_grant_cyc  = cyc;
            m_ack_cyc    = -1;
            m_req_cycles = 0;
            gnt[win]     = 1'b1;
            e_rdy0       = !win;
            e_rdy1       = win;
        end
        @(negedge clk);
        if (r0_ready) begin obs_gcyc.push_back(cyc); obs_gwho.push_back(1'b0); end
        if (r1_ready) begin obs_gcyc.push_back(cyc); obs_gwho.push_back(1'b1); end
        if (regf_req) obs_req_cnt++;
        chk("r0_ready", 32'(r0_ready), 32'(e_rdy0));
        chk("r1_ready", 32'(r1_ready), 32'(e_rdy1));
        chk("regf_req", 32'(regf_req), 32'(e_req));
        chk("r0_rsp_valid", 32'(r0_rsp_valid), 32'(e_rsp0));
        chk("r1_rsp_valid", 32'(r1_rsp_valid), 32'(e_rsp1));
        if (e_req) begin
            chk("regf_rw", 32'(regf_rw), 32'(m_txn.rw));
            chk("regf_addr", 32'(regf_addr), 32'(m_txn.a));
            chk("regf_wdata", 32'(regf_wdata), 32'(m_txn.d));
        end
        if (e_rsp0 || e_rsp1) begin
            chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
        end
        cyc++;
    endtask

    task automatic hold_reset(input int n);
        drive(NONE, NONE, 1'b0, '0);
        rst_n = 1'b0;
        #1;
        chk("rst_req_drop", 32'(regf_req), 32'd0);
        chk("rst_rsp0", 32'(r0_rsp_valid), 32'd0);
        chk("rst_rsp1", 32'(r1_rsp_valid), 32'd0);
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'({r1_ready, r0_ready}), 32'd0);
        chk("rst_regf_rw", 32'(regf_rw), 32'd0);
        chk("rst_regf_addr", 32'(regf_addr), 32'd0);
        chk("rst_regf_wdata", 32'(regf_wdata), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        m_busy     = 1'b0;
        m_pref     = 1'b0;
        m_free_cyc = cyc;
    endtask

    initial begin
        rq_t    p0, p1;
        bit [1:0] g;
        bit     exp_order [4];
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
        drive(NONE, NONE, 1'b0, '0);
        #2;
        hold_reset(2);

        // Single write from requester 0, ack in the first request cycle.
        step('{1'b1, 1'b1, 4'h3, 8'hA5}, NONE, 1'b0, 8'h00, g);
        step(NONE, NONE, 1'b1, 8'h77, g);
        step(NONE, NONE, 1'b0, 8'h00, g);

        // Read from requester 1 with ack in the third request cycle.
        step(NONE, '{1'b1, 1'b0, 4'h7, 8'h00}, 1'b0, 8'h11, g);
        step(NONE, NONE, 1'b0, 8'h22, g);
        step(NONE, NONE, 1'b0, 8'h33, g);
        step(NONE, NONE, 1'b1, 8'h5C, g);
        step(NONE, NONE, 1'b0, 8'h44, g);

        // Stray acks while idle must be ignored.
        for (int i = 0; i < 3; i++) step(NONE, NONE, 1'b1, 8'h99, g);

        // Requester 1 withdraws before being granted: no transaction results.
        step('{1'b1, 1'b0, 4'h1, 8'h00}, NONE, 1'b0, 8'h00, g);
        step(NONE, '{1'b1, 1'b1, 4'h2, 8'h6D}, 1'b0, 8'h00, g);
        step(NONE, NONE, 1'b1, 8'h81, g);
        for (int i = 0; i < 3; i++) step(NONE, NONE, 1'b0, 8'h00, g);

        // Contention from reset: strict alternation, one grant every 3 cycles.
        hold_reset(1);
        obs_gcyc.delete();
        obs_gwho.delete();
        for (int i = 0; i < 12; i++)
            step('{1'b1, 1'b0, 4'hA, 8'h01}, '{1'b1, 1'b1, 4'hB, 8'h02}, 1'b1, DW'($urandom), g);
        step(NONE, NONE, 1'b0, 8'h00, g);
        chk("cont_ngrants", 32'(obs_gwho.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < obs_gwho.size()) begin
                chk($sformatf("cont_who%0d", i), 32'(obs_gwho[i]), 32'(exp_order[i]));
                chk($sformatf("cont_gap%0d", i), 32'(obs_gcyc[i] - obs_gcyc[0]), 32'(3 * i));
            end
        end

        // Reset while a read is outstanding, then a normal requester 1 write.
        step('{1'b1, 1'b0, 4'h5, 8'h00}, NONE, 1'b0, 8'h00, g);
        step(NONE, NONE, 1'b0, 8'h00, g);
        hold_reset(2);
        step(NONE, '{1'b1, 1'b1, 4'h9, 8'h3E}, 1'b0, 8'h00, g);
        step(NONE, NONE, 1'b1, 8'hC4, g);
        step(NONE, NONE, 1'b0, 8'h00, g);

`ifdef REGF_ARB_WATCHDOG_EN
        // Ack never arrives: error response after the timeout.
        obs_req_cnt = 0;
        step('{1'b1, 1'b0, 4'h4, 8'h00}, NONE, 1'b0, 8'h00, g);
        for (int i = 0; i < 6; i++) step(NONE, NONE, 1'b0, 8'h00, g);
        chk("wdog_req_len", 32'(obs_req_cnt), 32'(WDOG));
        // Ack on the timeout cycle wins.
        step('{1'b1, 1'b0, 4'h6, 8'h00}, NONE, 1'b0, 8'h00, g);
        for (int i = 0; i < int'(WDOG) - 1; i++) step(NONE, NONE, 1'b0, 8'h00, g);
        step(NONE, NONE, 1'b1, 8'h3C, g);
        step(NONE, NONE, 1'b0, 8'h00, g);
`else
        // Without the watchdog a late ack is simply waited for.
        obs_req_cnt = 0;
        step('{1'b1, 1'b0, 4'h4, 8'h00}, NONE, 1'b0, 8'h00, g);
        for (int i = 0; i < 120; i++) step(NONE, NONE, 1'b0, 8'h00, g);
        step(NONE, NONE, 1'b1, 8'hE1, g);
        step(NONE, NONE, 1'b0, 8'h00, g);
        chk("long_req_len", 32'(obs_req_cnt), 32'd121);
`endif

        // Random traffic: requesters hold until accepted, random ack timing.
        p0 = NONE;
        p1 = NONE;
        for (int i = 0; i < 400; i++) begin
            if (!p0.v && $urandom_range(2) == 0) p0 = rand_rq();
            if (!p1.v && $urandom_range(2) == 0) p1 = rand_rq();
            step(p0, p1, ($urandom_range(2) == 0), DW'($urandom), g);
            if (g[0]) p0 = ($urandom_range(1) == 0) ? NONE : rand_rq();
            if (g[1]) p1 = ($urandom_range(1) == 0) ? NONE : rand_rq();
        end
        for (int i = 0; i < 8; i++) step(NONE, NONE, 1'b1, DW'($urandom), g);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regf_arbiter.md
Name: regf_arbiter

Overview:
- Shares the single register-file access port between two requesters: requester 0 (I2C slave controller) and requester 1 (local parallel host/debug port).
- Accepts one transaction at a time, sequences the register-file req/ack handshake, and returns read data or write completion to the originator.
- Sits between both requesters and the register file, inside the top-level wrapper.

Parameters:
- DATA_WIDTH, 8, register data width.
- ADDR_WIDTH, 4, register address width.
- WDOG_CYCLES, 16, ack timeout in clk cycles; used only with the optional feature; legal range 2..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- r0_valid  in  1  requester 0 request.
- r0_rw  in  1  requester 0 direction: 1 = write, 0 = read.
- r0_addr  in  ADDR_WIDTH  requester 0 address.
- r0_wdata  in  DATA_WIDTH  requester 0 write data.
- r0_ready  out  1  requester 0 request accepted; 1-cycle pulse.
- r0_rsp_valid  out  1  requester 0 response; 1-cycle pulse.
- r1_valid, r1_rw, r1_addr, r1_wdata, r1_ready, r1_rsp_valid  —  same as requester 0, for requester 1.
- rsp_rdata  out  DATA_WIDTH  read data; valid while either rsp_valid is high.
- rsp_err  out  1  response error flag; valid while either rsp_valid is high.
- regf_req  out  1  register-file request; held until ack.
- regf_rw  out  1  register-file direction.
- regf_addr  out  ADDR_WIDTH  register-file address.
- regf_wdata  out  DATA_WIDTH  register-file write data.
- regf_ack  in  1  register-file done; same or later cycle as regf_req.
- regf_rdata  in  DATA_WIDTH  register-file read data; sampled in the ack cycle.

Behaviour:
- Reset values (asynchronous, rst_n low): state = IDLE, rr_ptr = 0.
  - All outputs 0: regf_addr, regf_wdata, rsp_rdata all-zero; regf_req, ready, rsp_valid, rsp_err low.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Select the winning requester.
  - Pulse that requester's ready for 1 cycle.
  - Latch rw, addr and wdata into the regf_* output registers and record the owner; go to BUSY.
- Arbitration: round-robin.
  - rr_ptr names the preferred requester.
  - If only one requester is valid, it wins regardless of rr_ptr.
  - If both are valid, the rr_ptr requester wins.
  - After each grant, rr_ptr = the other requester.
  - After reset, requester 0 wins a simultaneous request.
- BUSY:
  - regf_req = 1; regf_* outputs stable.
  - On regf_ack: capture regf_rdata into rsp_rdata (0 for writes), rsp_err = 0, drop regf_req; go to RESP.
- RESP:
  - Owner's rsp_valid high for exactly 1 cycle; return to IDLE.
  - No new grant is made in the RESP cycle.
- Latency, with ack in the first BUSY cycle:
  - ready at cycle N.
  - regf_req high at N+1.
  - rsp_valid at N+2.
  - Next grant at N+3 at the earliest.
- Requester obligations:
  - Hold valid and payload until ready.
  - Drop valid in the cycle after ready, or keep it high to queue another transaction.
  - Changing the payload while valid is high before ready is a protocol violation; the arbiter samples only in the grant cycle.
- Valid deasserted before grant: no transaction, no response.
- regf_ack while in IDLE or RESP: ignored.
- rst_n asserted mid-transaction: the transaction is abandoned.
  - No response is issued after reset.
  - The register file sees regf_req drop asynchronously.
- Exactly one rsp_valid can be high at a time; never both.

Optional Feature:
- Macro: REGF_ARB_WATCHDOG_EN.
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches WDOG_CYCLES-1 without ack: drop regf_req, set rsp_rdata = all-ones and rsp_err = 1, go to RESP.
  - An ack in that same cycle wins: normal response, rsp_err = 0.
- Not defined: no counter; BUSY waits indefinitely; rsp_err is tied 0.

Decomposition:
- Package regf_arb_pkg:
  - State enum arb_state_t {IDLE, BUSY, RESP}.
  - Localparams RW_READ = 0, RW_WRITE = 1.
  - Requester IDs REQ_I2C = 0, REQ_LOCAL = 1.
- One sub-module: rr_arb2, a 2-input round-robin picker.
  - Inputs: valids, rr_ptr.
  - Outputs: grant one-hot, any.
  - Purely combinational; the pointer update stays in regf_arbiter.
- FSM, payload registers and watchdog all live in regf_arbiter.

Test Plan:
- Single write: r0 write addr 4'h3, data 8'hA5; register file acks in the first BUSY cycle.
  - r0_ready at N; regf_req high only at N+1 with addr 3, wdata A5, rw 1; r0_rsp_valid at N+2; rsp_err 0.
- Read with delayed ack: r1 read addr 4'h7; ack 3 cycles after regf_req; regf_rdata 8'h5C in the ack cycle.
  - regf_req held 3 cycles; r1_rsp_valid 1 cycle later with rsp_rdata 8'h5C; r0_rsp_valid stays 0.
- Contention: both valid from reset, held for 4 back-to-back transactions.
  - Grant order r0, r1, r0, r1.
  - Each grant 3 cycles apart with immediate ack.
  - Responses routed to the matching requester.
- Reset mid-BUSY: start r0 read, assert rst_n low before ack.
  - regf_req drops immediately; no rsp_valid.
  - After release, the next r1 request is serviced normally.
- Watchdog with REGF_ARB_WATCHDOG_EN and WDOG_CYCLES = 4: r0 read, ack never arrives.
  - regf_req high for exactly 4 cycles.
  - Then r0_rsp_valid with rsp_err 1 and rsp_rdata 8'hFF.
- Watchdog/ack tie with REGF_ARB_WATCHDOG_EN: ack lands on the timeout cycle.
  - Normal response with rsp_err 0.
  - Without the macro, the arbiter stays in BUSY for 100+ cycles until ack.
